interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Bus-mapped interrupt controller that sits between the peripheral interrupt sources (timer, mouse, IR transmitter, and future devices) and one interrupt input of the processor. It latches raise events per source, applies a mask and a global enable, and arbitrates by fixed or round-robin priority. It presents one request at a time to the CPU over the raise/ack handshake, then returns a one-cycle acknowledge to the selected source. The ISR identifies the serviced source by reading a vector register over the shared 8-bit data bus.

## Interface
- NUM_SRC, default 4: number of interrupt sources, legal range 1..8.
- BASE_ADDR, default 8'hE0: bus base address; occupies BASE_ADDR..BASE_ADDR+3.

- CLK  input  1  system clock; the single clock domain.
- RESET  input  1  synchronous, active-high reset.
- BUS_DATA  inout  8  shared data bus; driven only during this block's read slot, otherwise high-Z.
- BUS_ADDR  input  8  bus address.
- BUS_WE  input  1  bus write enable.
- SRC_RAISE  input  NUM_SRC  per-source interrupt raise.
- SRC_ACK  output  NUM_SRC  per-source acknowledge; one-cycle pulse.
- CPU_INT_RAISE  output  1  request to the CPU; connects to one BUS_INTERRUPTS_RAISE bit.
- CPU_INT_ACK  input  1  CPU acknowledge; connects to the matching BUS_INTERRUPTS_ACK bit.

## Operation
- Registers (offsets from BASE_ADDR); all bits at or above NUM_SRC read 0:
  - +0 MASK, R/W. Bit i = 1 enables source i. Reset 0x00.
  - +1 PENDING, R / write-1-to-clear. Reset 0x00.
  - +2 VECTOR, R. Bit7 = valid, [2:0] = id of the last acknowledged source. Reset 0x00. A read clears bit7 in the same cycle it is sampled.
  - +3 CTRL, R/W. Bit0 = global enable, bit1 = round-robin mode (0 = fixed priority). Reset 0x00.
- Event capture:
  - Each SRC_RAISE bit passes through a 1-flop edge detector: rise = SRC_RAISE & ~prev.
  - pending[i] is set on rise[i].
  - pending[i] is cleared on a W1C write or on the CPU ack for source i.
  - If set and clear occur in the same cycle, set wins.
- Candidate vector = PENDING & MASK, gated by CTRL[0].
- Arbitration:
  - Fixed priority mode: the lowest index wins.
  - Round-robin mode: search starts at last_served+1 and wraps modulo NUM_SRC. last_served resets to NUM_SRC-1, so the first search starts at 0.
- State machine:
  - IDLE: if candidate != 0, latch winner into sel and go to RAISE.
  - RAISE: CPU_INT_RAISE = 1. Wait for CPU_INT_ACK = 1, then go to ACKED. Clearing pending[sel] by W1C, or changing MASK or CTRL while in RAISE, does not abort the request; sel stays latched.
  - ACKED: for this one cycle, SRC_ACK[sel] = 1, pending[sel] is cleared, VECTOR = {1'b1, 4'b0, sel}, last_served = sel, CPU_INT_RAISE = 0. Then go to IDLE unconditionally.
- Masked pending bits stay latched. Setting the mask bit later raises the request.
- Bus write: when BUS_WE = 1 and BUS_ADDR is in range, the addressed register updates at the clock edge. Writes to VECTOR are ignored.
- Bus read: when BUS_WE = 0 and BUS_ADDR is in range, read data and an output-enable are registered. BUS_DATA is driven for exactly the next cycle, matching the RAM read timing.

## Timing
- Reset values: all outputs 0, BUS_DATA high-Z, state IDLE, all registers 0.
- RESET mid-handshake returns to IDLE at the next edge. CPU_INT_RAISE and SRC_ACK drop at that edge, and no SRC_ACK is issued.
- Latency from SRC_RAISE rising edge sampled at edge N:
  - pending is set at N+1.
  - IDLE sees the candidate in cycle N+1.
  - CPU_INT_RAISE is high from N+2.
- CPU_INT_ACK sampled at edge M: ACKED during cycle M+1, IDLE at M+2. The earliest next CPU_INT_RAISE is M+3. This guarantees at least one cycle low between requests.
- CPU_INT_ACK in IDLE or ACKED is ignored.
- Back-to-back raises of the same source before its ack collapse into one pending bit.

## Test plan
- Single source, MASK = 0x01, CTRL = 0x01, pulse SRC_RAISE[0] -> CPU_INT_RAISE rises 2 cycles later. Ack -> SRC_ACK[0] pulses for exactly 1 cycle, VECTOR reads 0x80, then a second VECTOR read returns 0x00.
- Fixed priority: raise sources 1 and 3 together, MASK = 0x0F -> source 1 is served first (VECTOR 0x81), then source 3 (0x83), with a ≥1-cycle low gap on CPU_INT_RAISE between them.
- Round-robin, CTRL = 0x03: sources 0 and 1 re-raise after every ack -> service order alternates 0, 1, 0, 1.
- Masking: raise source 2 with MASK = 0x00 -> no CPU_INT_RAISE and PENDING reads 0x04. Write MASK = 0x04 -> request appears 1 cycle later. W1C 0x04 before unmasking -> no request ever appears.
- Set wins: W1C pending[0] in the same cycle as a new rise[0] -> PENDING bit0 stays 1.
- Assert RESET while in RAISE -> CPU_INT_RAISE is 0 at the next edge, no SRC_ACK is issued, and all registers read 0x00.

Source files
------------

// File: rtl/interrupt_controller.sv
`default_nettype none
// ==== interrupt_controller : latched/masked interrupt sources, fixed or round-robin ====
// ==== arbitration, CPU raise/ack handshake, bus-mapped MASK/PENDING/VECTOR/CTRL; rev 1.0 ====
module interrupt_controller #(
   parameter int         NUM_SRC   = 4,
   parameter logic [7:0] BASE_ADDR = 8'hE0
) (
   input  logic               CLK,
   input  logic               RESET,
   inout  wire  [7:0]         BUS_DATA,
   input  logic [7:0]         BUS_ADDR,
   input  logic               BUS_WE,
   input  logic [NUM_SRC-1:0] SRC_RAISE,
   output logic [NUM_SRC-1:0] SRC_ACK,
   output logic               CPU_INT_RAISE,
   input  logic               CPU_INT_ACK
);

   localparam logic [1:0] OFF_MASK = 2'd0;
   localparam logic [1:0] OFF_PEND = 2'd1;
   localparam logic [1:0] OFF_VEC  = 2'd2;
   localparam logic [1:0] OFF_CTRL = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RAISE = 2'd1,
      S_ACKED = 2'd2
   } state_t;

   state_t             state;
   logic [2:0]         sel;
   logic [2:0]         last_served;
   logic [2:0]         winner;
   logic               win_found;
   int                 rr_start;

   logic [NUM_SRC-1:0] src_prev;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] pending_next;
   logic [NUM_SRC-1:0] mask;
   logic [NUM_SRC-1:0] candidate;
   logic [NUM_SRC-1:0] sel_onehot;
   logic [NUM_SRC-1:0] w1c_clr;
   logic [NUM_SRC-1:0] ack_clr;
   logic [1:0]         ctrl;
   logic               vec_valid;
   logic [2:0]         vec_id;

   logic [7:0]         addr_off;
   logic               in_range;
   logic [1:0]         reg_sel;
   logic               wr_en;
   logic               rd_en;
   logic               ack_evt;
   logic [7:0]         rd_mux;
   logic [7:0]         rd_data;
   logic               rd_oe;
   logic               unused_bus;

   // Offset arithmetic wraps, so the window is simply the four addresses from BASE_ADDR
   assign addr_off = BUS_ADDR - BASE_ADDR;
   assign in_range = (addr_off < 8'd4);
   assign reg_sel  = addr_off[1:0];
   assign wr_en    = BUS_WE & in_range;
   assign rd_en    = ~BUS_WE & in_range;

   assign BUS_DATA   = rd_oe ? rd_data : 8'bz;
   assign unused_bus = ^BUS_DATA;

   assign rise      = SRC_RAISE & ~src_prev;
   assign candidate = ctrl[0] ? (pending & mask) : '0;
   assign ack_evt   = (state == S_RAISE) && CPU_INT_ACK;
   assign w1c_clr   = (wr_en && reg_sel == OFF_PEND) ? BUS_DATA[NUM_SRC-1:0] : '0;
   assign ack_clr   = ack_evt ? sel_onehot : '0;

   // A new rise in the same cycle as a clear keeps the bit set
   assign pending_next = (pending & ~(w1c_clr | ack_clr)) | rise;

   always_comb begin
      sel_onehot = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         sel_onehot[i] = (sel == 3'(i));
      end
   end

   // Rotating search: fixed mode always starts at source 0
   always_comb begin
      winner    = 3'd0;
      win_found = 1'b0;
      rr_start  = 0;
      if (ctrl[1]) begin
         rr_start = (int'(last_served) + 1) % NUM_SRC;
      end
      for (int k = 0; k < NUM_SRC; k++) begin
         if (!win_found && candidate[(rr_start + k) % NUM_SRC]) begin
            win_found = 1'b1;
            winner    = 3'((rr_start + k) % NUM_SRC);
         end
      end
   end

   always_comb begin
      rd_mux = 8'h00;
      case (reg_sel)
         OFF_MASK: rd_mux[NUM_SRC-1:0] = mask;
         OFF_PEND: rd_mux[NUM_SRC-1:0] = pending;
         OFF_VEC:  rd_mux = {vec_valid, 4'b0000, vec_id};
         default:  rd_mux = {6'b000000, ctrl};
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         src_prev    <= '0;
         pending     <= '0;
         mask        <= '0;
         ctrl        <= 2'b00;
         vec_valid   <= 1'b0;
         vec_id      <= 3'd0;
         last_served <= 3'(NUM_SRC - 1);
         rd_data     <= 8'h00;
         rd_oe       <= 1'b0;
      end else begin
         src_prev <= SRC_RAISE;
         pending  <= pending_next;
         rd_oe    <= rd_en;
         rd_data  <= rd_en ? rd_mux : 8'h00;
         if (wr_en && reg_sel == OFF_MASK) begin
            mask <= BUS_DATA[NUM_SRC-1:0];
         end
         if (wr_en && reg_sel == OFF_CTRL) begin
            ctrl <= BUS_DATA[1:0];
         end
         if (rd_en && reg_sel == OFF_VEC) begin
            vec_valid <= 1'b0;
         end
         // A fresh acknowledge outranks a concurrent read-clear of the valid bit
         if (ack_evt) begin
            vec_valid   <= 1'b1;
            vec_id      <= sel;
            last_served <= sel;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state         <= S_IDLE;
         sel           <= 3'd0;
         CPU_INT_RAISE <= 1'b0;
         SRC_ACK       <= '0;
      end else begin
         SRC_ACK <= '0;
         case (state)
            S_IDLE: begin
               if (win_found) begin
                  sel           <= winner;
                  state         <= S_RAISE;
                  CPU_INT_RAISE <= 1'b1;
               end
            end
            S_RAISE: begin
               if (CPU_INT_ACK) begin
                  state         <= S_ACKED;
                  CPU_INT_RAISE <= 1'b0;
                  SRC_ACK       <= sel_onehot;
               end
            end
            S_ACKED: begin
               state <= S_IDLE;
            end
            default: begin
               state         <= S_IDLE;
               CPU_INT_RAISE <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// tb_interrupt_controller: directed and randomized checks of interrupt_controller
// against a transaction-level model of pending bits, masking and service order.
module tb_interrupt_controller;

   localparam int         NUM_SRC = 4;
   localparam logic [7:0] BASE    = 8'hE0;

   logic       clk = 1'b0;
   logic       rst;
   wire  [7:0] bus;
   logic [7:0] addr;
   logic       we;
   logic       drv_en;
   logic [7:0] drv_data;
   logic [3:0] src_raise;
   logic [3:0] src_ack;
   logic       cpu_raise;
   logic       cpu_ack;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [3:0] m_pend;
   logic [3:0] m_mask;
   logic       m_en;
   logic       m_rr;
   int         m_last;

   assign bus = drv_en ? drv_data : 8'bz;

   always #5 clk = ~clk;

   interrupt_controller #(
      .NUM_SRC  (NUM_SRC),
      .BASE_ADDR(BASE)
   ) dut (
      .CLK          (clk),
      .RESET        (rst),
      .BUS_DATA     (bus),
      .BUS_ADDR     (addr),
      .BUS_WE       (we),
      .SRC_RAISE    (src_raise),
      .SRC_ACK      (src_ack),
      .CPU_INT_RAISE(cpu_raise),
      .CPU_INT_ACK  (cpu_ack)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_pend = 4'b0;
      m_mask = 4'b0;
      m_en   = 1'b0;
      m_rr   = 1'b0;
      m_last = NUM_SRC - 1;
   endtask

   // Winner = enabled pending source with the smallest distance from the search origin
   function automatic int model_winner();
      int best      = -1;
      int best_dist = 99;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (m_en && m_pend[i] && m_mask[i]) begin
            int d;
            d = m_rr ? ((i - m_last - 1 + 2 * NUM_SRC) % NUM_SRC) : i;
            if (d < best_dist) begin
               best_dist = d;
               best      = i;
            end
         end
      end
      return best;
   endfunction

   task automatic bus_write(input logic [1:0] off, input logic [7:0] data, input logic [3:0] raise);
      addr      = BASE + {6'b0, off};
      we        = 1'b1;
      drv_en    = 1'b1;
      drv_data  = data;
      src_raise = raise;
      tick();
      addr      = 8'h00;
      we        = 1'b0;
      drv_en    = 1'b0;
      src_raise = 4'b0;
   endtask

   task automatic bus_read(input logic [1:0] off, output logic [7:0] data);
      addr = BASE + {6'b0, off};
      we   = 1'b0;
      tick();
      addr = 8'h00;
      data = bus;
      tick();
   endtask

   task automatic pulse(input logic [3:0] bits);
      src_raise = bits;
      tick();
      src_raise = 4'b0;
   endtask

   task automatic wait_raise();
      int n = 0;
      while (cpu_raise !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("raise_wait", 8'(cpu_raise), 8'h01);
   endtask

   // Service one request; rearm sources raise again on the very ack edge
   task automatic serve(input int exp, input logic [3:0] rearm);
      logic [7:0] v;
      wait_raise();
      cpu_ack   = 1'b1;
      src_raise = rearm;
      tick();
      cpu_ack   = 1'b0;
      src_raise = 4'b0;
      check("src_ack", 8'(src_ack), 8'(1 << exp));
      check("raise_low_acked", 8'(cpu_raise), 8'h00);
      tick();
      check("ack_one_cycle", 8'(src_ack), 8'h00);
      check("raise_gap", 8'(cpu_raise), 8'h00);
      bus_read(2'd2, v);
      check("vector", v, 8'(128 + exp));
      m_pend[exp] = 1'b0;
      m_pend      = m_pend | rearm;
      m_last      = exp;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] v;
      rst       = 1'b1;
      addr      = 8'h00;
      we        = 1'b0;
      drv_en    = 1'b0;
      drv_data  = 8'h00;
      src_raise = 4'b0;
      cpu_ack   = 1'b0;
      model_reset();
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_raise", 8'(cpu_raise), 8'h00);
      check("rst_src_ack", 8'(src_ack), 8'h00);
      for (int r = 0; r < 4; r++) begin
         bus_read(2'(r), v);
         check("rst_reg", v, 8'h00);
      end

      // Single source: raise two cycles after the pulse, vector valid then cleared by read
      bus_write(2'd0, 8'h01, 4'b0);
      bus_write(2'd3, 8'h01, 4'b0);
      m_mask = 4'h1;
      m_en   = 1'b1;
      pulse(4'b0001);
      m_pend = 4'b0001;
      check("single_raise_early", 8'(cpu_raise), 8'h00);
      tick();
      check("single_raise_on", 8'(cpu_raise), 8'h01);
      bus_read(2'd1, v);
      check("single_pending", v, 8'h01);
      serve(0, 4'b0);
      bus_read(2'd2, v);
      check("vector_reread", v, 8'h00);
      bus_read(2'd1, v);
      check("single_pending_clr", v, 8'h00);

      // Fixed priority: lower index first
      bus_write(2'd0, 8'h0F, 4'b0);
      m_mask = 4'hF;
      pulse(4'b1010);
      m_pend = 4'b1010;
      serve(1, 4'b0);
      serve(3, 4'b0);

      // Round-robin with re-raise on each ack
      bus_write(2'd3, 8'h03, 4'b0);
      bus_write(2'd0, 8'h03, 4'b0);
      m_rr   = 1'b1;
      m_mask = 4'h3;
      pulse(4'b0011);
      m_pend = 4'b0011;
      serve(0, 4'b0001);
      serve(1, 4'b0010);
      serve(0, 4'b0001);
      serve(1, 4'b0000);
      serve(0, 4'b0000);

      // Masking: latched while masked, request one cycle after unmask
      bus_write(2'd3, 8'h01, 4'b0);
      bus_write(2'd0, 8'h00, 4'b0);
      m_rr   = 1'b0;
      m_mask = 4'h0;
      pulse(4'b0100);
      repeat (3) tick();
      check("masked_no_raise", 8'(cpu_raise), 8'h00);
      bus_read(2'd1, v);
      check("masked_pending", v, 8'h04);
      bus_write(2'd0, 8'h04, 4'b0);
      check("unmask_raise_early", 8'(cpu_raise), 8'h00);
      tick();
      check("unmask_raise_on", 8'(cpu_raise), 8'h01);
      m_mask = 4'h4;
      m_pend = 4'b0100;
      serve(2, 4'b0);

      // W1C before unmasking: nothing ever requested
      bus_write(2'd0, 8'h00, 4'b0);
      pulse(4'b0100);
      tick();
      bus_write(2'd1, 8'h04, 4'b0);
      bus_read(2'd1, v);
      check("w1c_pending", v, 8'h00);
      bus_write(2'd0, 8'h04, 4'b0);
      repeat (4) tick();
      check("w1c_no_raise", 8'(cpu_raise), 8'h00);

      // Set wins over a same-cycle W1C
      bus_write(2'd0, 8'h00, 4'b0);
      pulse(4'b0001);
      tick();
      bus_write(2'd1, 8'h01, 4'b0001);
      bus_read(2'd1, v);
      check("set_wins", v, 8'h01);
      bus_write(2'd1, 8'h01, 4'b0);
      bus_read(2'd1, v);
      check("set_wins_clr", v, 8'h00);

      // Reset during RAISE with ack present: no acknowledge, everything cleared
      bus_write(2'd0, 8'h01, 4'b0);
      bus_write(2'd3, 8'h01, 4'b0);
      pulse(4'b0001);
      tick();
      check("rst_hs_raise_on", 8'(cpu_raise), 8'h01);
      rst     = 1'b1;
      cpu_ack = 1'b1;
      tick();
      check("rst_hs_raise", 8'(cpu_raise), 8'h00);
      check("rst_hs_ack", 8'(src_ack), 8'h00);
      rst     = 1'b0;
      cpu_ack = 1'b0;
      tick();
      check("rst_hs_ack_after", 8'(src_ack), 8'h00);
      model_reset();
      for (int r = 0; r < 4; r++) begin
         bus_read(2'(r), v);
         check("rst_hs_reg", v, 8'h00);
      end
      check("rst_hs_idle", 8'(cpu_raise), 8'h00);

      // Randomized rounds against the model
      for (int r = 0; r < 24; r++) begin
         logic [3:0] rs;
         int         w;
         int         served;
         m_mask = 4'($urandom_range(0, 15));
         m_en   = ($urandom_range(0, 3) != 0);
         m_rr   = 1'($urandom_range(0, 1));
         bus_write(2'd0, {4'b0, m_mask}, 4'b0);
         bus_write(2'd3, {6'b0, m_rr, m_en}, 4'b0);
         rs = 4'($urandom_range(1, 15));
         pulse(rs);
         m_pend = m_pend | rs;
         served = 0;
         w      = model_winner();
         while (w >= 0 && served < 8) begin
            serve(w, (served < 2) ? 4'($urandom_range(0, 15)) : 4'b0);
            served++;
            w = model_winner();
         end
         repeat (3) tick();
         check("rnd_no_raise", 8'(cpu_raise), 8'h00);
         bus_read(2'd1, v);
         check("rnd_pending", v, {4'b0, m_pend});
         bus_write(2'd1, 8'hFF, 4'b0);
         m_pend = 4'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
